// File: rtl/complex_dot_acc.sv
// Purpose: streaming complex dot product, LANES complex MACs per beat, one sum per last-terminated vector.
// Latency: last beat accepted at edge t -> out_valid_o after edge t+3; one beat per cycle.
// Backpressure: an unconsumed result freezes every stage and drops in_ready_o; flush_i aborts all work.
module complex_dot_acc #(
    parameter int LANES   = 4,
    parameter int DATA_W  = 16,
    parameter int GUARD_W = 8,
    parameter int ACC_W   = 2*DATA_W + 1 + $clog2(LANES) + GUARD_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [LANES*DATA_W-1:0]   a_re_i,
    input  logic [LANES*DATA_W-1:0]   a_im_i,
    input  logic [LANES*DATA_W-1:0]   b_re_i,
    input  logic [LANES*DATA_W-1:0]   b_im_i,
    input  logic                      conj_i,
    input  logic                      last_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      flush_i,
    output logic [ACC_W-1:0]          res_re_o,
    output logic [ACC_W-1:0]          res_im_o,
    output logic                      ovf_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      busy_o
);

    localparam int PROD_W = 2*DATA_W;
    localparam int LANE_W = PROD_W + 1;

    logic en;
    logic take;

    // Stage control bits
    logic s1_vld_q, s1_conj_q, s1_last_q;
    logic s2_vld_q, s2_last_q;
    logic b_vld_q, b_last_q;

    // Datapath
    logic signed [PROD_W-1:0] p_rr [LANES];
    logic signed [PROD_W-1:0] p_ii [LANES];
    logic signed [PROD_W-1:0] p_ir [LANES];
    logic signed [PROD_W-1:0] p_ri [LANES];
    logic signed [PROD_W-1:0] s1_rr_q [LANES];
    logic signed [PROD_W-1:0] s1_ii_q [LANES];
    logic signed [PROD_W-1:0] s1_ir_q [LANES];
    logic signed [PROD_W-1:0] s1_ri_q [LANES];
    logic signed [LANE_W-1:0] lane_re [LANES];
    logic signed [LANE_W-1:0] lane_im [LANES];
    logic signed [LANE_W-1:0] s2_re_q [LANES];
    logic signed [LANE_W-1:0] s2_im_q [LANES];
    logic signed [ACC_W-1:0]  tree_re, tree_im;
    logic signed [ACC_W-1:0]  beat_re_q, beat_im_q;
    logic signed [ACC_W-1:0]  acc_re_q, acc_im_q;
    logic signed [ACC_W-1:0]  base_re, base_im;
    logic signed [ACC_W-1:0]  nxt_re, nxt_im;
    logic signed [ACC_W-1:0]  res_re_q, res_im_q;
    logic                     open_q, sticky_q, ovf_q, out_valid_q;
    logic                     ovf_re, ovf_im, beat_ovf;

    // The whole pipe only moves when the result register is free or being drained.
    assign en         = ~(out_valid_q & ~out_ready_i);
    assign in_ready_o = en & ~flush_i & ~rst_i;
    assign take       = in_valid_i & in_ready_o;

    // Per-lane products from the raw inputs, and the re/im combine from the S1 registers.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DATA_W-1:0] ar, ai, br, bi;
        assign ar = a_re_i[k*DATA_W +: DATA_W];
        assign ai = a_im_i[k*DATA_W +: DATA_W];
        assign br = b_re_i[k*DATA_W +: DATA_W];
        assign bi = b_im_i[k*DATA_W +: DATA_W];
        assign p_rr[k] = PROD_W'(ar) * PROD_W'(br);
        assign p_ii[k] = PROD_W'(ai) * PROD_W'(bi);
        assign p_ir[k] = PROD_W'(ai) * PROD_W'(br);
        assign p_ri[k] = PROD_W'(ar) * PROD_W'(bi);
        assign lane_re[k] = s1_conj_q ? (LANE_W'(s1_rr_q[k]) + LANE_W'(s1_ii_q[k]))
                                      : (LANE_W'(s1_rr_q[k]) - LANE_W'(s1_ii_q[k]));
        assign lane_im[k] = s1_conj_q ? (LANE_W'(s1_ir_q[k]) - LANE_W'(s1_ri_q[k]))
                                      : (LANE_W'(s1_ir_q[k]) + LANE_W'(s1_ri_q[k]));
    end

    // Adder tree over the registered lane sums, sign-extended to the accumulator width.
    always_comb begin
        tree_re = '0;
        tree_im = '0;
        for (int k = 0; k < LANES; k++) begin
            tree_re = tree_re + ACC_W'(s2_re_q[k]);
            tree_im = tree_im + ACC_W'(s2_im_q[k]);
        end
    end

    // Accumulate: a closed vector restarts from zero; overflow is a same-sign add flipping sign.
    always_comb begin
        base_re  = open_q ? acc_re_q : '0;
        base_im  = open_q ? acc_im_q : '0;
        nxt_re   = base_re + beat_re_q;
        nxt_im   = base_im + beat_im_q;
        ovf_re   = (base_re[ACC_W-1] == beat_re_q[ACC_W-1]) && (nxt_re[ACC_W-1] != base_re[ACC_W-1]);
        ovf_im   = (base_im[ACC_W-1] == beat_im_q[ACC_W-1]) && (nxt_im[ACC_W-1] != base_im[ACC_W-1]);
        beat_ovf = ovf_re | ovf_im;
    end

    // Stage valid/control pipeline; flush wipes every in-flight beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld_q  <= 1'b0;
            s1_conj_q <= 1'b0;
            s1_last_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            b_vld_q   <= 1'b0;
            b_last_q  <= 1'b0;
        end else if (flush_i) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            b_vld_q   <= 1'b0;
        end else if (en) begin
            s1_vld_q  <= take;
            s1_conj_q <= conj_i;
            s1_last_q <= last_i;
            s2_vld_q  <= s1_vld_q;
            s2_last_q <= s1_last_q;
            b_vld_q   <= s2_vld_q;
            b_last_q  <= s2_last_q;
        end
    end

    // Datapath registers carry no reset; they are only consumed under their stage valid.
    always_ff @(posedge clk_i) begin
        if (en) begin
            for (int k = 0; k < LANES; k++) begin
                s1_rr_q[k] <= p_rr[k];
                s1_ii_q[k] <= p_ii[k];
                s1_ir_q[k] <= p_ir[k];
                s1_ri_q[k] <= p_ri[k];
                s2_re_q[k] <= lane_re[k];
                s2_im_q[k] <= lane_im[k];
            end
            beat_re_q <= tree_re;
            beat_im_q <= tree_im;
        end
    end

    // Accumulator, sticky overflow and result register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            open_q      <= 1'b0;
            sticky_q    <= 1'b0;
            res_re_q    <= '0;
            res_im_q    <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush_i) begin
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            open_q      <= 1'b0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            out_valid_q <= b_vld_q & b_last_q;
            if (b_vld_q) begin
                if (b_last_q) begin
                    res_re_q <= nxt_re;
                    res_im_q <= nxt_im;
                    ovf_q    <= sticky_q | beat_ovf;
                    acc_re_q <= '0;
                    acc_im_q <= '0;
                    open_q   <= 1'b0;
                    sticky_q <= 1'b0;
                end else begin
                    acc_re_q <= nxt_re;
                    acc_im_q <= nxt_im;
                    open_q   <= 1'b1;
                    sticky_q <= sticky_q | beat_ovf;
                end
            end
        end
    end

    assign res_re_o    = res_re_q;
    assign res_im_o    = res_im_q;
    assign ovf_o       = ovf_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = s1_vld_q | s2_vld_q | b_vld_q | open_q | out_valid_q;

endmodule
